id_regread: RTL
===============

ID_REGREAD -- requirements
Module: id_regread

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of register, read-data and immediate paths.
REQ-002 Parameter ADDR_WIDTH, default 5: register index width; register file holds 2**ADDR_WIDTH entries.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst_n  input  1  reset; asynchronous and active-low.
REQ-005 IF_Instr  input  32  instruction held in the IF/ID register.
REQ-006 IF_Valid  input  1  IF_Instr is a real instruction, not a bubble.
REQ-007 Ctrl_MemRead  input  1  main control decode of IF_Instr: instruction is a load.
REQ-008 Flush  input  1  discard the instruction currently in decode.
REQ-009 WB_RegWrite  input  1  writeback-stage write enable.
REQ-010 WB_WriteReg  input  ADDR_WIDTH  writeback destination register.
REQ-011 WB_WriteData  input  DATA_WIDTH  writeback data.
REQ-012 Stall  output  1  hold PC and IF/ID this cycle (combinational).
REQ-013 EX_Valid  output  1  ID/EX register holds a real instruction.
REQ-014 EX_MemRead  output  1  registered copy of Ctrl_MemRead.
REQ-015 EX_ReadData1 / EX_ReadData2  output  DATA_WIDTH each  registered rs / rt operand values.
REQ-016 EX_Rs / EX_Rt / EX_Rd  output  ADDR_WIDTH each  registered IF_Instr[25:21] / [20:16] / [15:11].
REQ-017 EX_Imm  output  DATA_WIDTH  registered sign extension of IF_Instr[15:0].

Function
REQ-018 Register file of 2**ADDR_WIDTH x DATA_WIDTH; written at rising Clk when WB_RegWrite=1 and WB_WriteReg!=0.
REQ-019 Register 0 reads 0 always; writes to register 0 are dropped, not stored.
REQ-020 Reads are combinational from the array, indexed by IF_Instr rs and rt fields.
REQ-021 Write-to-read bypass: if WB_RegWrite=1, WB_WriteReg!=0 and WB_WriteReg equals the read index, that port returns WB_WriteData in the same cycle; applies to both ports independently.
REQ-022 Load-use hazard: Stall=1 iff IF_Valid=1, EX_Valid=1, EX_MemRead=1, EX_Rt!=0 and (EX_Rt==rs field or EX_Rt==rt field); Stall=0 otherwise.
REQ-023 Flush=1 forces Stall=0 regardless of REQ-022.
REQ-024 ID/EX register updates every rising Clk; no enable input.
REQ-025 Bubble load (EX_Valid=0, EX_MemRead=0, all other EX_* outputs 0) when Flush=1, Stall=1 or IF_Valid=0; priority Flush > Stall > normal.
REQ-026 Normal load: EX_Valid=1, EX_MemRead=Ctrl_MemRead, EX_ReadData1/2 = bypassed read values, fields and EX_Imm from IF_Instr.
REQ-027 Decode-to-EX latency exactly 1 cycle; a stalled instruction reaches ID/EX on the first cycle Stall is 0, and Stall never lasts more than 1 consecutive cycle for the same instruction.
REQ-028 Register-file write and ID/EX capture in the same edge are independent; the bypass of REQ-021 guarantees the new value is captured.

Reset
REQ-029 Rst_n=0 asynchronously clears all register-file entries to 0 and all ID/EX outputs to 0 (EX_Valid=0, EX_MemRead=0), independent of Clk.
REQ-030 While Rst_n=0, Stall=0 and writeback writes are ignored; first update occurs on the first rising Clk after Rst_n deasserts.
REQ-031 Assertion of reset mid-stall drops the stall and the pending instruction state immediately.

Verification
REQ-032 Write R5=0x1234_5678 via WB, next cycle decode rs=5 -> EX_ReadData1=0x1234_5678 one cycle later.
REQ-033 WB writes R7=0xDEAD_BEEF in the same cycle decode reads rt=7 -> EX_ReadData2=0xDEAD_BEEF (bypass); WB write to R0=0xFFFF_FFFF -> subsequent read of R0 returns 0.
REQ-034 lw to rt=8 in ID/EX, decode add with rs=8 -> Stall=1 for one cycle, bubble (EX_Valid=0) inserted, add captured next cycle with Stall=0.
REQ-035 Same hazard as REQ-034 with Flush=1 -> Stall=0, bubble captured; lw with rt=0 followed by consumer of R0 -> no stall.
REQ-036 IF_Instr[15:0]=0x8000 -> EX_Imm=0xFFFF_8000; 0x7FFF -> 0x0000_7FFF.
REQ-037 Assert Rst_n=0 between clock edges during a stall -> all EX_* outputs and Stall go 0 without a clock edge; R5 reads 0 after release.

Source files
------------

// File: rtl/id_regread.sv
// id_regread: instruction-decode register read stage.
//   Holds the architectural register file, reads the rs/rt operands with a
//   writeback bypass, detects load-use hazards and loads the ID/EX register.
// Ports:
//   Clk, Rst_n                 clock, asynchronous active-low reset
//   IF_Instr, IF_Valid         instruction in IF/ID and its valid bit
//   Ctrl_MemRead               main-control "is a load" decode of IF_Instr
//   Flush                      discard the instruction currently in decode
//   WB_RegWrite/WriteReg/Data  writeback port into the register file
//   Stall                      combinational hold request for PC and IF/ID
//   EX_*                       registered ID/EX pipeline register contents
module id_regread #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  Clk,
   input  logic                  Rst_n,
   input  logic [31:0]           IF_Instr,
   input  logic                  IF_Valid,
   input  logic                  Ctrl_MemRead,
   input  logic                  Flush,
   input  logic                  WB_RegWrite,
   input  logic [ADDR_WIDTH-1:0] WB_WriteReg,
   input  logic [DATA_WIDTH-1:0] WB_WriteData,
   output logic                  Stall,
   output logic                  EX_Valid,
   output logic                  EX_MemRead,
   output logic [DATA_WIDTH-1:0] EX_ReadData1,
   output logic [DATA_WIDTH-1:0] EX_ReadData2,
   output logic [ADDR_WIDTH-1:0] EX_Rs,
   output logic [ADDR_WIDTH-1:0] EX_Rt,
   output logic [ADDR_WIDTH-1:0] EX_Rd,
   output logic [DATA_WIDTH-1:0] EX_Imm
);

   localparam int NREG = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NREG];

   logic [ADDR_WIDTH-1:0] rs, rt, rd;
   logic [DATA_WIDTH-1:0] rd1, rd2, imm;
   logic                  wr_en;
   logic                  bubble;
   logic                  unused_opcode;

   // opcode is decoded by main control outside this block
   assign unused_opcode = &{1'b0, IF_Instr[31:26]};

   assign rs  = ADDR_WIDTH'(IF_Instr[25:21]);
   assign rt  = ADDR_WIDTH'(IF_Instr[20:16]);
   assign rd  = ADDR_WIDTH'(IF_Instr[15:11]);
   assign imm = {{(DATA_WIDTH-16){IF_Instr[15]}}, IF_Instr[15:0]};

   // writes to r0 never take effect, so they never bypass either
   assign wr_en = WB_RegWrite && (WB_WriteReg != '0);

   // r0 is forced to zero on read; bypass covers write-then-read in one cycle
   always_comb begin
      rd1 = regs[rs];
      if (rs == '0)
         rd1 = '0;
      else if (wr_en && (WB_WriteReg == rs))
         rd1 = WB_WriteData;

      rd2 = regs[rt];
      if (rt == '0)
         rd2 = '0;
      else if (wr_en && (WB_WriteReg == rt))
         rd2 = WB_WriteData;
   end

   // load-use: the load in EX cannot forward in time, so hold decode one cycle.
   // The bubble inserted below clears EX_Valid, so a stall never repeats.
   assign Stall = !Flush && IF_Valid && EX_Valid && EX_MemRead &&
                  (EX_Rt != '0) && ((EX_Rt == rs) || (EX_Rt == rt));

   assign bubble = Flush || Stall || !IF_Valid;

   // register file
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (wr_en) begin
         regs[WB_WriteReg] <= WB_WriteData;
      end
   end

   // ID/EX pipeline register, updated every cycle
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         EX_Valid     <= 1'b0;
         EX_MemRead   <= 1'b0;
         EX_ReadData1 <= '0;
         EX_ReadData2 <= '0;
         EX_Rs        <= '0;
         EX_Rt        <= '0;
         EX_Rd        <= '0;
         EX_Imm       <= '0;
      end else if (bubble) begin
         EX_Valid     <= 1'b0;
         EX_MemRead   <= 1'b0;
         EX_ReadData1 <= '0;
         EX_ReadData2 <= '0;
         EX_Rs        <= '0;
         EX_Rt        <= '0;
         EX_Rd        <= '0;
         EX_Imm       <= '0;
      end else begin
         EX_Valid     <= 1'b1;
         EX_MemRead   <= Ctrl_MemRead;
         EX_ReadData1 <= rd1;
         EX_ReadData2 <= rd2;
         EX_Rs        <= rs;
         EX_Rt        <= rt;
         EX_Rd        <= rd;
         EX_Imm       <= imm;
      end
   end

endmodule
